// File: rtl/matmul_ctrl_param_if.sv
// ---------------------------------------------------------------------------
// matmul_ctrl_param_if
// Handshake/control bundle between the top-level start logic (master) and the
// matrix-vector sequencing controller (slave).
//   start_in      master->slave  job request
//   xload_done    master->slave  input shift register finished loading A/X
//   abort         master->slave  cancel the current job
//   input_load_en slave->master  load phase active
//   alu_en        slave->master  MAC datapath enable
//   acc_clr       slave->master  clear accumulators (first MAC of a column)
//   mac_idx       slave->master  MAC cycle within the column (MW bits)
//   col_idx       slave->master  current column (CW bits)
//   wr_en         slave->master  write the finished column result at col_idx
//   busy          slave->master  controller not idle
//   done          slave->master  one-cycle job-complete pulse
// ---------------------------------------------------------------------------
interface matmul_ctrl_param_if #(
  parameter int CW = 2,
  parameter int MW = 3
);
  logic          start_in;
  logic          xload_done;
  logic          abort;
  logic          input_load_en;
  logic          alu_en;
  logic          acc_clr;
  logic [MW-1:0] mac_idx;
  logic [CW-1:0] col_idx;
  logic          wr_en;
  logic          busy;
  logic          done;

  modport master (
    output start_in, xload_done, abort,
    input  input_load_en, alu_en, acc_clr, mac_idx, col_idx, wr_en, busy, done
  );

  modport slave (
    input  start_in, xload_done, abort,
    output input_load_en, alu_en, acc_clr, mac_idx, col_idx, wr_en, busy, done
  );
endinterface

// File: rtl/matmul_ctrl_param.sv
// ---------------------------------------------------------------------------
// matmul_ctrl_param
// Sequencing controller for the matrix-vector datapath: LOAD the inputs, then
// for each of N_COLS columns run N_MAC ALU cycles followed by one NEXT_COL
// (result write) cycle, then pulse done. abort (or rst) returns to IDLE from
// any state. With AUTO_RESTART=1 a start seen in DONE goes straight to LOAD.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  matmul_ctrl_param_if.slave (see interface header for signal list)
// All outputs are registers, computed from the next state and counters, so
// no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module matmul_ctrl_param #(
  parameter int N_COLS       = 4,
  parameter int N_MAC        = 8,
  parameter int AUTO_RESTART = 0
) (
  input logic                clk,
  input logic                rst,
  matmul_ctrl_param_if.slave bus
);

  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int MW = (N_MAC > 1) ? $clog2(N_MAC) : 1;
  localparam logic [MW-1:0] MAC_LAST = MW'(N_MAC - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_ALU      = 3'd2,
    S_NEXT_COL = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [MW-1:0] mac_q, mac_d;
  logic [CW-1:0] col_q, col_d;

  logic load_en_q, load_en_d;
  logic alu_en_q, alu_en_d;
  logic acc_clr_q, acc_clr_d;
  logic wr_en_q, wr_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Next-state and counter update; abort overrides every other condition.
  always_comb begin
    state_d = state_q;
    mac_d   = mac_q;
    col_d   = col_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      mac_d   = {MW{1'b0}};
      col_d   = {CW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          mac_d = {MW{1'b0}};
          col_d = {CW{1'b0}};
          if (bus.start_in) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          if (bus.xload_done) begin
            state_d = S_ALU;
            mac_d   = {MW{1'b0}};
          end else begin
            state_d = S_LOAD;
          end
        end
        S_ALU: begin
          // Terminal compare instead of wrap keeps mac_idx within N_MAC-1
          // even when N_MAC is not a power of two.
          if (mac_q == MAC_LAST) begin
            state_d = S_NEXT_COL;
            mac_d   = {MW{1'b0}};
          end else begin
            mac_d   = mac_q + {{(MW-1){1'b0}}, 1'b1};
          end
        end
        S_NEXT_COL: begin
          if (col_q == COL_LAST) begin
            state_d = S_DONE;
            col_d   = {CW{1'b0}};
          end else begin
            state_d = S_ALU;
            col_d   = col_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          if ((AUTO_RESTART != 0) && bus.start_in) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          mac_d   = {MW{1'b0}};
          col_d   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs line up with
  // the state they describe.
  always_comb begin
    load_en_d = (state_d == S_LOAD);
    alu_en_d  = (state_d == S_ALU);
    acc_clr_d = (state_d == S_ALU) && (mac_d == {MW{1'b0}});
    wr_en_d   = (state_d == S_NEXT_COL);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mac_q     <= {MW{1'b0}};
      col_q     <= {CW{1'b0}};
      load_en_q <= 1'b0;
      alu_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mac_q     <= mac_d;
      col_q     <= col_d;
      load_en_q <= load_en_d;
      alu_en_q  <= alu_en_d;
      acc_clr_q <= acc_clr_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.input_load_en = load_en_q;
  assign bus.alu_en        = alu_en_q;
  assign bus.acc_clr       = acc_clr_q;
  assign bus.mac_idx       = mac_q;
  assign bus.col_idx       = col_q;
  assign bus.wr_en         = wr_en_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_matmul_ctrl_param.sv
module tb_matmul_ctrl_param;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // A: default sizes, no auto-restart.  B: 1 column, 1 MAC, auto-restart.
  matmul_ctrl_param_if #(.CW(2), .MW(3)) if_a ();
  matmul_ctrl_param_if #(.CW(1), .MW(1)) if_b ();

  matmul_ctrl_param #(.N_COLS(4), .N_MAC(8), .AUTO_RESTART(0)) dut_a (
    .clk(clk), .rst(rst_a), .bus(if_a)
  );
  matmul_ctrl_param #(.N_COLS(1), .N_MAC(1), .AUTO_RESTART(1)) dut_b (
    .clk(clk), .rst(rst_b), .bus(if_b)
  );

  typedef struct packed {
    logic busy; logic ld; logic alu; logic clr; logic wr; logic done;
    int mac; int col;
  } obs_t;

  // Job progress model: mode 0 idle, 1 load, 2 running; k counts cycles
  // since leaving LOAD (k == ncols*(nmac+1) is the DONE cycle).
  typedef struct packed { int mode; int k; } mst_t;

  mst_t st_a = '0;
  mst_t st_b = '0;
  obs_t hist [0:63];

  function automatic obs_t model_out(mst_t s, int ncols, int nmac);
    obs_t o;
    o = '0;
    o.busy = (s.mode != 0);
    o.ld   = (s.mode == 1);
    if (s.mode == 2) begin
      if (s.k == ncols * (nmac + 1)) begin
        o.done = 1'b1;
      end else begin
        o.col = s.k / (nmac + 1);
        if ((s.k % (nmac + 1)) < nmac) begin
          o.alu = 1'b1;
          o.mac = s.k % (nmac + 1);
          o.clr = (o.mac == 0);
        end else begin
          o.wr = 1'b1;
        end
      end
    end
    return o;
  endfunction

  function automatic mst_t model_next(mst_t s, logic r, logic st, logic xl, logic ab,
                                      int ncols, int nmac, int autor);
    mst_t n;
    n = s;
    if (r || ab) begin
      n.mode = 0; n.k = 0;
    end else if (s.mode == 0) begin
      if (st) n.mode = 1;
    end else if (s.mode == 1) begin
      if (xl) begin n.mode = 2; n.k = 0; end
    end else if (s.k < ncols * (nmac + 1)) begin
      n.k = s.k + 1;
    end else begin
      n.mode = (autor != 0 && st) ? 1 : 0;
      n.k = 0;
    end
    return n;
  endfunction

  function automatic obs_t samp_a();
    obs_t o;
    o.busy = if_a.busy; o.ld = if_a.input_load_en; o.alu = if_a.alu_en;
    o.clr = if_a.acc_clr; o.wr = if_a.wr_en; o.done = if_a.done;
    o.mac = int'(if_a.mac_idx); o.col = int'(if_a.col_idx);
    return o;
  endfunction

  function automatic obs_t samp_b();
    obs_t o;
    o.busy = if_b.busy; o.ld = if_b.input_load_en; o.alu = if_b.alu_en;
    o.clr = if_b.acc_clr; o.wr = if_b.wr_en; o.done = if_b.done;
    o.mac = int'(if_b.mac_idx); o.col = int'(if_b.col_idx);
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got busy/ld/alu/clr/wr/done=%b%b%b%b%b%b mac=%0d col=%0d expected %b%b%b%b%b%b mac=%0d col=%0d (t=%0t)",
               name, act.busy, act.ld, act.alu, act.clr, act.wr, act.done, act.mac, act.col,
               exp.busy, exp.ld, exp.alu, exp.clr, exp.wr, exp.done, exp.mac, exp.col, $time);
    end
  endtask

  // Model advance on each rising edge using the inputs the DUT samples.
  always @(posedge clk) begin
    st_a <= model_next(st_a, rst_a, if_a.start_in, if_a.xload_done, if_a.abort, 4, 8, 0);
    st_b <= model_next(st_b, rst_b, if_b.start_in, if_b.xload_done, if_b.abort, 1, 1, 1);
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk_obs("model_a", samp_a(), model_out(st_a, 4, 8));
      chk_obs("model_b", samp_b(), model_out(st_b, 1, 1));
    end
  end

  // Runs one job on DUT A, recording outputs per cycle into hist[1..ncyc].
  task automatic run_a(input int lx, input int ab_t, input int rs_t, input int ncyc);
    @(negedge clk); #1;
    if_a.start_in = 1'b1;
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk); #1;
      if_a.start_in   = 1'b0;
      if_a.xload_done = (t == 1 + lx);
      if_a.abort      = (t == ab_t);
      rst_a           = (t == rs_t);
      hist[t]         = samp_a();
    end
    @(negedge clk); #1;
    if_a.xload_done = 1'b0;
    if_a.abort      = 1'b0;
    rst_a           = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_exp [4];
    int clr_exp [4];
    int n_ld, n_done, done_t, n_wr, n_clr, n_late;
    mst_t pin;
    wr_exp  = '{10, 19, 28, 37};
    clr_exp = '{2, 11, 20, 29};
    for (int i = 0; i < 64; i++) hist[i] = '0;
    if_a.start_in = 1'b0; if_a.xload_done = 1'b0; if_a.abort = 1'b0;
    if_b.start_in = 1'b0; if_b.xload_done = 1'b0; if_b.abort = 1'b0;
    @(negedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state, literal.
    chk("rst_busy", int'(if_a.busy), 0);
    chk("rst_outs", int'({if_a.input_load_en, if_a.alu_en, if_a.acc_clr, if_a.wr_en, if_a.done}), 0);
    chk("rst_idx", int'(if_a.mac_idx) + int'(if_a.col_idx), 0);

    // Pin the model with hand-computed points.
    pin.mode = 2; pin.k = 36;
    chk("pin_done", int'(model_out(pin, 4, 8).done), 1);
    pin.k = 26;
    chk("pin_wr_col2", int'(model_out(pin, 4, 8).wr) * 10 + model_out(pin, 4, 8).col, 12);

    // Test 1: default job, xload_done in first LOAD cycle.
    run_a(0, 0, 0, 45);
    n_done = 0; done_t = -1; n_wr = 0; n_clr = 0;
    for (int t = 1; t <= 45; t++) begin
      if (hist[t].done) begin n_done++; done_t = t; end
      if (hist[t].wr) begin
        if (n_wr < 4) begin
          chk("t1_wr_cyc", t, wr_exp[n_wr]);
          chk("t1_wr_col", hist[t].col, n_wr);
        end
        n_wr++;
      end
      if (hist[t].clr) begin
        if (n_clr < 4) chk("t1_clr_cyc", t, clr_exp[n_clr]);
        n_clr++;
      end
    end
    chk("t1_done_n", n_done, 1);
    chk("t1_done_cyc", done_t, 38);
    chk("t1_wr_n", n_wr, 4);
    chk("t1_clr_n", n_clr, 4);
    chk("t1_idle_after", int'(hist[39].busy), 0);
    chk("t1_busy_first", int'(hist[1].busy), 1);

    // Test 2: LOAD stall of 5 extra cycles.
    run_a(5, 0, 0, 50);
    n_ld = 0; done_t = -1;
    for (int t = 1; t <= 50; t++) begin
      if (hist[t].ld) n_ld++;
      if (hist[t].done) done_t = t;
    end
    chk("t2_ld_cycles", n_ld, 6);
    chk("t2_done_cyc", done_t, 43);

    // Test 3: abort in ALU at col 2, mac 3 (cycle 23).
    run_a(0, 23, 0, 50);
    chk("t3_at_col", hist[23].col, 2);
    chk("t3_at_mac", hist[23].mac, 3);
    chk("t3_next_busy", int'(hist[24].busy), 0);
    chk("t3_next_idx", hist[24].col + hist[24].mac, 0);
    n_late = 0;
    for (int t = 24; t <= 50; t++) begin
      if (hist[t].wr || hist[t].done || hist[t].busy) n_late++;
    end
    chk("t3_no_activity", n_late, 0);

    // Test 4: abort and start together in IDLE.
    @(negedge clk); #1;
    if_a.start_in = 1'b1; if_a.abort = 1'b1;
    @(negedge clk); #1;
    if_a.start_in = 1'b0; if_a.abort = 1'b0;
    chk("t4_busy0", int'(if_a.busy), 0);
    chk("t4_ld0", int'(if_a.input_load_en), 0);
    @(negedge clk); #1;
    chk("t4_busy1", int'(if_a.busy), 0);

    // Test 5: DUT B, 1x1 with auto-restart and start held high.
    @(negedge clk); #1;
    if_b.start_in = 1'b1; if_b.xload_done = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk); #1;
      chk("t5_busy", int'(if_b.busy), 1);
      chk("t5_ld", int'(if_b.input_load_en), int'(t % 4 == 1));
      chk("t5_alu_clr", int'({if_b.alu_en, if_b.acc_clr}), (t % 4 == 2) ? 3 : 0);
      chk("t5_wr", int'(if_b.wr_en), int'(t % 4 == 3));
      chk("t5_done", int'(if_b.done), int'(t % 4 == 0));
    end
    if_b.start_in = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("t5_stop_busy", int'(if_b.busy), 0);
    if_b.xload_done = 1'b0;

    // Test 6: reset pulsed mid NEXT_COL (cycle 10), then a fresh job.
    run_a(0, 0, 10, 14);
    chk("t6_wr_before", int'(hist[10].wr) * 10 + hist[10].col, 10);
    chk("t6_after_rst", int'(hist[11]), 0);
    run_a(0, 0, 0, 45);
    done_t = -1; n_wr = 0;
    for (int t = 1; t <= 45; t++) begin
      if (hist[t].done) done_t = t;
      if (hist[t].wr) n_wr++;
    end
    chk("t6_done_cyc", done_t, 38);
    chk("t6_wr_n", n_wr, 4);

    repeat (2) @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
